// File: rtl/front_end_ctrl_pkg.sv
// Shared Qu front-end types: controller state encoding and redirect cause,
// plus the priority resolver used when redirect requests coincide.
package qu_common;

  localparam int QU_PC_WIDTH = 32;

  typedef enum logic [2:0] {
    FE_IDLE     = 3'd0,
    FE_BOOT     = 3'd1,
    FE_RUN      = 3'd2,
    FE_FLUSH    = 3'd3,
    FE_REDIRECT = 3'd4
  } fe_ctrl_state_t;

  typedef enum logic [1:0] {
    RC_NONE   = 2'd0,
    RC_BRANCH = 2'd1,
    RC_JUMP   = 2'd2,
    RC_EXC    = 2'd3
  } redirect_cause_t;

  // Exception wins over jump, jump over branch.
  function automatic redirect_cause_t pick_cause(logic exc, logic jmp, logic br);
    if (exc)      return RC_EXC;
    else if (jmp) return RC_JUMP;
    else if (br)  return RC_BRANCH;
    else          return RC_NONE;
  endfunction

endpackage

// File: rtl/front_end_ctrl_if.sv
// Control bundle between front_end_ctrl (master) and the front end it sequences.
interface front_end_ctrl_if
  import qu_common::*;
#(
  parameter int PC_WIDTH  = QU_PC_WIDTH,
  parameter int CNT_WIDTH = 32
) ();

  logic                 start;
  logic                 branch;
  logic                 jump;
  logic                 exception;
  logic [PC_WIDTH-1:0]  redirect_target;
  logic                 rob_full;
  logic                 rs_full;
  logic                 ext_stall;
  logic                 if_id_full;
  logic                 id_mp_full;
  logic                 mp_rn_full;

  logic                 if_en;
  logic                 id_en;
  logic                 if_stall;
  logic                 id_stall;
  logic                 mp_stall;
  logic                 rn_stall;
  logic                 flush;
  logic                 redirect;
  redirect_cause_t      redirect_cause;
  logic [PC_WIDTH-1:0]  pc_override;
  logic [CNT_WIDTH-1:0] stall_cnt;

  modport master (
    input  start, branch, jump, exception, redirect_target,
           rob_full, rs_full, ext_stall, if_id_full, id_mp_full, mp_rn_full,
    output if_en, id_en, if_stall, id_stall, mp_stall, rn_stall,
           flush, redirect, redirect_cause, pc_override, stall_cnt
  );

  modport slave (
    output start, branch, jump, exception, redirect_target,
           rob_full, rs_full, ext_stall, if_id_full, id_mp_full, mp_rn_full,
    input  if_en, id_en, if_stall, id_stall, mp_stall, rn_stall,
           flush, redirect, redirect_cause, pc_override, stall_cnt
  );

endinterface

// File: rtl/front_end_ctrl_sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones, async clear.
module qu_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      cnt <= '0;
    else if (en && !(&cnt))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/front_end_ctrl.sv
// Front-end sequencer: boot, back-pressure stalls, and the flush/redirect
// sequence for branch, jump and exception events.
module front_end_ctrl
  import qu_common::*;
#(
  parameter int                   PC_WIDTH     = QU_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
  parameter logic [PC_WIDTH-1:0]  EXC_VECTOR   = 'h100,
  parameter int                   FLUSH_CYCLES = 2,
  parameter int                   CNT_WIDTH    = 32
) (
  input logic              clk,
  input logic              rst_n,
  front_end_ctrl_if.master fe
);

  localparam int             FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  fe_ctrl_state_t      state_q, state_d;
  logic [FC_W-1:0]     cnt_q, cnt_d;
  redirect_cause_t     lat_cause_q, lat_cause_d;
  logic [PC_WIDTH-1:0] lat_tgt_q, lat_tgt_d;
  redirect_cause_t     out_cause_q, out_cause_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                run_d1;
  logic                st_if, st_id, st_mp, st_rn;
  logic                stall_en;
  logic [CNT_WIDTH-1:0] stall_cnt_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FE_IDLE;
      cnt_q       <= '0;
      lat_cause_q <= RC_NONE;
      lat_tgt_q   <= RESET_PC;
      out_cause_q <= RC_NONE;
      out_pc_q    <= RESET_PC;
      run_d1      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_cause_q <= lat_cause_d;
      lat_tgt_q   <= lat_tgt_d;
      out_cause_q <= out_cause_d;
      out_pc_q    <= out_pc_d;
      // id_en waits one RUN cycle so decode never sees an unfilled slot
      run_d1      <= (state_q == FE_RUN);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_cause_d = lat_cause_q;
    lat_tgt_d   = lat_tgt_q;
    out_cause_d = out_cause_q;
    out_pc_d    = out_pc_q;
    st_if       = 1'b1;
    st_id       = 1'b1;
    st_mp       = 1'b1;
    st_rn       = 1'b1;

    case (state_q)
      FE_IDLE: begin
        if (fe.start) begin
          state_d     = FE_BOOT;
          out_cause_d = RC_JUMP;
          out_pc_d    = RESET_PC;
        end
      end
      FE_BOOT: state_d = FE_RUN;
      FE_RUN: begin
        st_if = fe.if_id_full;
        st_id = fe.id_mp_full;
        st_mp = fe.mp_rn_full;
        st_rn = fe.rob_full | fe.rs_full | fe.ext_stall;
        if (fe.branch | fe.jump | fe.exception) begin
          state_d     = FE_FLUSH;
          cnt_d       = FC_LOAD;
          lat_cause_d = pick_cause(fe.exception, fe.jump, fe.branch);
          lat_tgt_d   = fe.exception ? EXC_VECTOR : fe.redirect_target;
        end
      end
      FE_FLUSH: begin
        // a late exception restarts the flush window and overrides the target
        if (fe.exception) begin
          cnt_d       = FC_LOAD;
          lat_cause_d = RC_EXC;
          lat_tgt_d   = EXC_VECTOR;
        end else if (cnt_q == '0) begin
          state_d     = FE_REDIRECT;
          out_cause_d = lat_cause_q;
          out_pc_d    = lat_tgt_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FE_REDIRECT: state_d = FE_RUN;
      default: state_d = FE_IDLE;
    endcase
  end

  assign stall_en = (state_q == FE_RUN) && (st_if | st_id | st_mp | st_rn);

  qu_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (stall_en),
    .cnt   (stall_cnt_w)
  );

  assign fe.if_en          = (state_q == FE_RUN);
  assign fe.id_en          = (state_q == FE_RUN) && run_d1;
  assign fe.if_stall       = st_if;
  assign fe.id_stall       = st_id;
  assign fe.mp_stall       = st_mp;
  assign fe.rn_stall       = st_rn;
  assign fe.flush          = (state_q == FE_FLUSH);
  assign fe.redirect       = (state_q == FE_BOOT) || (state_q == FE_REDIRECT);
  assign fe.redirect_cause = out_cause_q;
  assign fe.pc_override    = out_pc_q;
  assign fe.stall_cnt      = stall_cnt_w;

endmodule

// File: doc/front_end_ctrl.md
# front_end_ctrl

Sequencing controller for the Qu front end. Brings the fetch/decode/map/rename pipeline out of reset, drives the per-stage enables and stalls from downstream back-pressure, and performs the flush-and-redirect sequence on branch, jump and exception events. Sits beside `front_end`; its outputs drive that block's `if_en`, `id_en`, `*_stall` and `pc_override` inputs.

## Interface
- `PC_WIDTH`, `QU_PC_WIDTH`: width of all PC values.
- `RESET_PC`, `'0`: boot fetch address.
- `EXC_VECTOR`, `'h100`: exception redirect target.
- `FLUSH_CYCLES`, `2`: cycles the front end is held in flush (≥1).
- `CNT_WIDTH`, `32`: width of the stall performance counter.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  leave IDLE and boot.
- `branch`, `jump`, `exception`  in  1 each  redirect requests, single-cycle pulses.
- `redirect_target`  in  PC_WIDTH  target for branch/jump.
- `rob_full`, `rs_full`, `ext_stall`  in  1 each  back-end back-pressure.
- `if_id_full`, `id_mp_full`, `mp_rn_full`  in  1 each  inter-stage FIFO full flags.
- `if_en`, `id_en`  out  1 each  stage enables.
- `if_stall`, `id_stall`, `mp_stall`, `rn_stall`  out  1 each  stage stalls.
- `flush`  out  1  front-end flush, level.
- `redirect`  out  1  one-cycle PC override strobe.
- `redirect_cause`  out  2  NONE=0, BRANCH=1, JUMP=2, EXC=3.
- `pc_override`  out  PC_WIDTH  redirect address, valid with `redirect`.
- `stall_cnt`  out  CNT_WIDTH  saturating stall-cycle count.

## Operation
- States: IDLE, BOOT, RUN, FLUSH, REDIRECT.
- IDLE: enables 0, all stalls 1, `flush` 0. `start`=1 → BOOT.
- BOOT (1 cycle): `redirect`=1, cause JUMP, `pc_override`=RESET_PC → RUN.
- RUN: `if_en`=1 every RUN cycle; `id_en`=1 from the second consecutive RUN cycle onward (pipeline fill).
  - `rn_stall`=rob_full|rs_full|ext_stall.
  - `mp_stall`=mp_rn_full.
  - `id_stall`=id_mp_full.
  - `if_stall`=if_id_full.
  - Stalls are combinational from inputs in RUN only.
- Redirect request in RUN → FLUSH. Latch cause and target: EXC→EXC_VECTOR, else `redirect_target`.
  - Priority when requests coincide: exception > jump > branch.
- FLUSH: `flush`=1, enables 0, all stalls 1. Down-counter loads FLUSH_CYCLES−1 and exits to REDIRECT at 0.
  - `exception` during FLUSH: relatch EXC_VECTOR, cause EXC, reload the counter.
  - `branch`/`jump` during FLUSH: ignored.
- REDIRECT (1 cycle): `redirect`=1, latched cause/target on outputs, enables 0, stalls 1 → RUN.
  - Requests in this cycle are ignored.
- `stall_cnt`: +1 per RUN cycle with any stall output high. Saturates at all-ones, never wraps.
- `start` is ignored outside IDLE.

## Timing
- Reset (async, any state): state IDLE, `if_en`/`id_en`/`flush`/`redirect`=0, all stalls=1, `redirect_cause`=NONE, `pc_override`=RESET_PC, `stall_cnt`=0, counter=0.
- `start` sampled at edge t: BOOT in cycle t+1, RUN from t+2 (`if_en`), `id_en` from t+3.
- Redirect pulse sampled at edge t in RUN:
  - `flush` high cycles t+1…t+FLUSH_CYCLES.
  - `redirect` at t+FLUSH_CYCLES+1.
  - `if_en` at t+FLUSH_CYCLES+2; `id_en` one cycle later.
- `pc_override` and `redirect_cause` are registered and hold their last value outside redirect strobes.
- Deassertion of `rst_n` is synchronous to `clk`; the first edge after release evaluates IDLE.

## Structure
- Shared package `qu_common`: add `fe_ctrl_state_t` (state enum) and `redirect_cause_t` (2-bit enum).
- One natural sub-module: `qu_sat_counter` (parameterised width, enable, async active-low clear) for `stall_cnt`.
- FSM, flush counter and latch registers stay in this module.

## Test plan
- Boot: reset, `start`=1 one cycle.
  - → `redirect`=1, cause 2, `pc_override`=0 one cycle later.
  - → `if_en` next cycle, `id_en` the cycle after.
- Back-pressure: in RUN drive `rob_full`=1 for 5 cycles, then `id_mp_full`=1 for 3.
  - → `rn_stall` high 5 cycles, `id_stall` high 3, `stall_cnt`=8.
- Branch: `branch`=1, `redirect_target`=0x40, FLUSH_CYCLES=2.
  - → `flush` 2 cycles, enables 0.
  - → `redirect`=1 cause 1 `pc_override`=0x40.
  - → `if_en`=1.
- Priority: `branch` and `exception` same cycle, then `exception` again during FLUSH.
  - → single redirect, cause 3, `pc_override`=0x100.
  - → flush lasts 2 cycles from the second exception.
- Reset mid-FLUSH: drop `rst_n` asynchronously.
  - → all outputs at reset values immediately.
  - → no `redirect` after release until `start`.
- Saturation: CNT_WIDTH=4, hold `ext_stall` 20 RUN cycles → `stall_cnt`=15, stays 15.
